// File: rtl/pi_series_sequencer.sv
// Leibniz-series pi in fixed point, sharing one restoring divider across all terms.
// Latency 1 + N*(W+2) cycles from start to done; start is only accepted in IDLE, with no other flow control.
module pi_series_sequencer #(
   parameter int FRAC      = 48,
   parameter int INT       = 3,
   parameter int TERM_BITS = 16
) (
   input  logic                    clk_2,
   input  logic                    reset,
   input  logic                    start,
   input  logic [TERM_BITS-1:0]    n_terms,
   output logic                    busy,
   output logic                    done,
   output logic                    stopped_zero,
   output logic [FRAC+INT:0]       pi,
   output logic [TERM_BITS:0]      a_cur,
   output logic [TERM_BITS-1:0]    term_count
);

   localparam int W  = FRAC + INT + 1;
   localparam int CW = $clog2(W);
   localparam logic [W-1:0]         M       = {{(W-1){1'b0}}, 1'b1} << (FRAC + 2);
   localparam logic [TERM_BITS:0]   A_STEP  = 2;
   localparam logic [TERM_BITS:0]   A_FIRST = 1;
   localparam logic [TERM_BITS-1:0] TC_ONE  = 1;
   localparam logic [CW-1:0]        BIT_TOP = CW'(W - 1);
   localparam logic [CW-1:0]        BIT_ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_LOAD,
      S_DIV,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t               state;
   logic [TERM_BITS-1:0] n_lat;
   logic                 sign_neg;
   logic [W-1:0]         dividend;
   logic [W-1:0]         quot;
   logic [TERM_BITS:0]   divisor;
   logic [TERM_BITS:0]   rem;
   logic [CW-1:0]        bit_cnt;

   // Remainder never reaches the divisor, so one extra bit covers the shifted value.
   logic [TERM_BITS+1:0] rem_shift;
   logic [TERM_BITS:0]   rem_sub;
   logic                 fits;
   logic [TERM_BITS-1:0] tc_next;

   always_comb begin
      rem_shift = {rem, dividend[W-1]};
      fits      = rem_shift >= {1'b0, divisor};
      rem_sub   = rem_shift[TERM_BITS:0] - divisor;
      tc_next   = term_count + TC_ONE;
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         stopped_zero <= 1'b0;
         pi           <= '0;
         a_cur        <= A_FIRST;
         term_count   <= '0;
         n_lat        <= '0;
         sign_neg     <= 1'b0;
         dividend     <= '0;
         quot         <= '0;
         divisor      <= '0;
         rem          <= '0;
         bit_cnt      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  n_lat <= n_terms;
                  busy  <= 1'b1;
                  state <= S_INIT;
               end
            end
            S_INIT: begin
               pi           <= '0;
               a_cur        <= A_FIRST;
               term_count   <= '0;
               stopped_zero <= 1'b0;
               sign_neg     <= 1'b0;
               if (n_lat == '0) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               dividend <= M;
               divisor  <= a_cur;
               rem      <= '0;
               quot     <= '0;
               bit_cnt  <= BIT_TOP;
               state    <= S_DIV;
            end
            S_DIV: begin
               dividend <= dividend << 1;
               quot     <= {quot[W-2:0], fits};
               rem      <= fits ? rem_sub : rem_shift[TERM_BITS:0];
               if (bit_cnt == '0) begin
                  state <= S_ACCUM;
               end else begin
                  bit_cnt <= bit_cnt - BIT_ONE;
               end
            end
            S_ACCUM: begin
               if (quot == '0) begin
                  stopped_zero <= 1'b1;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  state        <= S_DONE;
               end else begin
                  // Partial sums stay within (0,4], so wrap-free in W bits.
                  pi         <= sign_neg ? (pi - quot) : (pi + quot);
                  term_count <= tc_next;
                  a_cur      <= a_cur + A_STEP;
                  sign_neg   <= ~sign_neg;
                  if (tc_next == n_lat) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     state <= S_LOAD;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pi_series_sequencer.sv
// Scoreboard bench for pi_series_sequencer at FRAC=8, INT=3 (W=12, M=1024).
module tb_pi_series_sequencer;

   localparam int FRAC      = 8;
   localparam int INT       = 3;
   localparam int TERM_BITS = 16;
   localparam int W         = FRAC + INT + 1;

   logic                 clk_2 = 1'b0;
   logic                 reset = 1'b1;
   logic                 start = 1'b0;
   logic [TERM_BITS-1:0] n_terms = '0;
   logic                 busy;
   logic                 done;
   logic                 stopped_zero;
   logic [W-1:0]         pi;
   logic [TERM_BITS:0]   a_cur;
   logic [TERM_BITS-1:0] term_count;

   pi_series_sequencer #(
      .FRAC(FRAC), .INT(INT), .TERM_BITS(TERM_BITS)
   ) dut (
      .clk_2(clk_2),
      .reset(reset),
      .start(start),
      .n_terms(n_terms),
      .busy(busy),
      .done(done),
      .stopped_zero(stopped_zero),
      .pi(pi),
      .a_cur(a_cur),
      .term_count(term_count)
   );

   always #5 clk_2 = ~clk_2;

   int cyc = 0;
   always @(posedge clk_2) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0]         pi;
      logic [TERM_BITS-1:0] tc;
      logic [TERM_BITS:0]   a;
      logic                 sz;
      int                   at_cyc;
   } done_exp_t;

   typedef struct {
      logic [W-1:0]         pi;
      logic [TERM_BITS-1:0] tc;
      logic [TERM_BITS:0]   a;
   } term_exp_t;

   done_exp_t done_q[$];
   term_exp_t term_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_done(input logic [W-1:0] p, input logic [TERM_BITS-1:0] tc,
                            input logic [TERM_BITS:0] a, input logic sz, input int at);
      done_exp_t e;
      e.pi = p; e.tc = tc; e.a = a; e.sz = sz; e.at_cyc = at;
      done_q.push_back(e);
   endtask

   task automatic push_term(input logic [W-1:0] p, input logic [TERM_BITS-1:0] tc,
                            input logic [TERM_BITS:0] a);
      term_exp_t e;
      e.pi = p; e.tc = tc; e.a = a;
      term_q.push_back(e);
   endtask

   // Monitor: pops expectations on each done pulse and on each term accumulation.
   logic                 prev_done = 1'b0;
   logic [TERM_BITS-1:0] prev_tc = '0;
   always @(negedge clk_2) begin
      if (done) begin
         check("done_one_cycle", prev_done, 0);
         if (done_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
         end else begin
            done_exp_t e;
            e = done_q.pop_front();
            check("done_pi", pi, e.pi);
            check("done_term_count", term_count, e.tc);
            check("done_a_cur", a_cur, e.a);
            check("done_stopped_zero", stopped_zero, e.sz);
            check("done_cycle", cyc, e.at_cyc);
            check("done_busy", busy, 0);
         end
      end
      if (!reset && term_count != prev_tc && term_count != '0) begin
         if (term_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_term: got term_count=%0d, expected no update", term_count);
         end else begin
            term_exp_t t;
            t = term_q.pop_front();
            check("term_pi", pi, t.pi);
            check("term_count_step", term_count, t.tc);
            check("term_a_cur", a_cur, t.a);
         end
      end
      prev_done <= done;
      prev_tc   <= term_count;
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pi"}, pi, 0);
      check({tag, "_a_cur"}, a_cur, 1);
      check({tag, "_term_count"}, term_count, 0);
      check({tag, "_stopped_zero"}, stopped_zero, 0);
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!done && k < budget) begin
         @(negedge clk_2);
         k++;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", budget);
      end
   endtask

   // Issues start at the next edge; rel is the edge (from the start edge) at which DONE is entered.
   task automatic run(input logic [TERM_BITS-1:0] n, input int rel, input logic [W-1:0] p,
                      input logic [TERM_BITS-1:0] tc, input logic [TERM_BITS:0] a, input logic sz);
      @(negedge clk_2);
      push_done(p, tc, a, sz, cyc + 1 + rel);
      n_terms = n;
      start   = 1'b1;
      @(negedge clk_2);
      start = 1'b0;
      wait_done(rel + 20);
      @(negedge clk_2);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk_2);
   endtask

   initial begin
      int c0;
      int pm;
      int q;
      logic neg;

      // Reset and idle
      reset = 1'b1;
      repeat (2) @(posedge clk_2);
      @(negedge clk_2);
      reset = 1'b0;
      repeat (5) @(negedge clk_2);
      check_reset_vals("idle");

      // Four terms: quotients 1024, 341, 204, 146
      push_term(12'd1024, 16'd1, 17'd3);
      push_term(12'd683,  16'd2, 17'd5);
      push_term(12'd887,  16'd3, 17'd7);
      push_term(12'd741,  16'd4, 17'd9);
      run(16'd4, 57, 12'd741, 16'd4, 17'd9, 1'b0);

      // Zero terms: INIT in the cycle after the start edge, DONE right after it
      @(negedge clk_2);
      c0 = cyc + 1;
      push_done(12'd0, 16'd0, 17'd1, 1'b0, c0 + 1);
      n_terms = 16'd0;
      start   = 1'b1;
      @(negedge clk_2);
      start = 1'b0;
      check("n0_busy_in_init", busy, 1);
      @(negedge clk_2);
      check("n0_busy_in_done", busy, 0);
      wait_done(5);
      @(negedge clk_2);

      // 600 requested terms: stops at a_cur=1025 where 1024/1025 = 0
      pm  = 0;
      neg = 1'b0;
      for (int k = 0; k < 512; k++) begin
         q  = 1024 / (2 * k + 1);
         pm = neg ? pm - q : pm + q;
         neg = ~neg;
         push_term(W'(pm), TERM_BITS'(k + 1), (TERM_BITS + 1)'(2 * k + 3));
      end
      run(16'd600, 7183, W'(pm), 16'd512, 17'd1025, 1'b1);

      // Reset in the middle of a four-term run
      @(negedge clk_2);
      c0 = cyc + 1;
      push_term(12'd1024, 16'd1, 17'd3);
      n_terms = 16'd4;
      start   = 1'b1;
      @(negedge clk_2);
      start = 1'b0;
      wait_until(c0 + 20);
      reset = 1'b1;
      @(negedge clk_2);
      reset = 1'b0;
      check_reset_vals("abort");
      repeat (70) @(negedge clk_2);
      push_term(12'd1024, 16'd1, 17'd3);
      run(16'd1, 15, 12'd1024, 16'd1, 17'd3, 1'b0);

      // start held high: one run of 2 terms, then a new run sampled in IDLE with n_terms=1
      @(negedge clk_2);
      c0 = cyc + 1;
      push_term(12'd1024, 16'd1, 17'd3);
      push_term(12'd683,  16'd2, 17'd5);
      push_done(12'd683, 16'd2, 17'd5, 1'b0, c0 + 29);
      push_term(12'd1024, 16'd1, 17'd3);
      push_done(12'd1024, 16'd1, 17'd3, 1'b0, c0 + 31 + 15);
      n_terms = 16'd2;
      start   = 1'b1;
      @(negedge clk_2);
      n_terms = 16'd1;
      wait_until(c0 + 30);
      check("held_busy_in_idle", busy, 0);
      wait_until(c0 + 31);
      check("held_restart_busy", busy, 1);
      start = 1'b0;
      @(negedge clk_2);
      check("held_restart_a_cur", a_cur, 1);
      check("held_restart_pi", pi, 0);
      wait_until(c0 + 60);

      check("done_queue_drained", done_q.size(), 0);
      check("term_queue_drained", term_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no end of test by cycle %0d, expected completion", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
